// File: rtl/ysyx_22050612_dmem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_22050612_dmem_resp: single-outstanding data-memory responder with a  |
// | programmable access latency over valid/ready request/response channels.   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module ysyx_22050612_dmem_resp #(
  parameter int          ADDR_W  = 10,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [63:0] C_LIMIT  = BASE + (64'd8 << ADDR_W);
  localparam logic [7:0]  C_LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                we_q, err_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [63:0]         wdata_q;
  logic [7:0]          wmask_q;
  logic [63:0]         mem_q [2**ADDR_W];

  logic                w_accept, w_enter_resp, w_mem_we;
  logic                w_req_err, w_we, w_err;
  logic [63:0]         w_off, w_wdata;
  logic [ADDR_W-1:0]   w_req_idx, w_idx;
  logic [7:0]          w_wmask;

  assign w_accept  = (state_q == IDLE) && req_valid && req_ready_q;
  assign w_req_err = (req_addr < BASE) || (req_addr >= C_LIMIT);
  assign w_off     = req_addr - BASE;
  assign w_req_idx = ADDR_W'(w_off >> 3);

  // With LATENCY == 1 the response is formed on the accept edge itself, so the
  // live request fields stand in for the not-yet-captured ones.
  assign w_we    = (state_q == IDLE) ? req_we    : we_q;
  assign w_err   = (state_q == IDLE) ? w_req_err : err_q;
  assign w_idx   = (state_q == IDLE) ? w_req_idx : idx_q;
  assign w_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign w_wmask = (state_q == IDLE) ? req_wmask : wmask_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    rdata_d      = rdata_q;
    resp_err_d   = resp_err_q;
    w_enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (w_accept) begin
          req_ready_d = 1'b0;
          cnt_d       = C_LAT_M1;
          if (LATENCY > 1) state_d = BUSY;
          else             w_enter_resp = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) w_enter_resp = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          resp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_enter_resp) begin
      state_d    = RESP;
      resp_err_d = w_err;
      rdata_d    = (w_err || w_we) ? 64'd0 : mem_q[w_idx];
    end
  end

  assign w_mem_we = w_enter_resp && w_we && !w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      req_ready_q <= 1'b0;
      rdata_q     <= 64'd0;
      resp_err_q  <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 64'd0;
      wmask_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rdata_q     <= rdata_d;
      resp_err_q  <= resp_err_d;
      if (w_accept) begin
        we_q    <= req_we;
        err_q   <= w_req_err;
        idx_q   <= w_req_idx;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (w_wmask[i]) mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_dmem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx_22050612_dmem_resp: scoreboard bench, three responders at         |
// | LATENCY 2 / 4 / 1.  Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
module tb_ysyx_22050612_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n, req_valid, req_we, resp_ready;
  logic [2:0][63:0] req_addr, req_wdata;
  logic [2:0][7:0]  req_wmask;
  wire  [2:0]       req_ready, resp_valid, resp_err;
  wire  [2:0][63:0] resp_rdata;

  ysyx_22050612_dmem_resp #(.ADDR_W(10), .BASE(64'h8000_0000), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  ysyx_22050612_dmem_resp #(.ADDR_W(10), .BASE(64'h8000_0000), .LATENCY(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  ysyx_22050612_dmem_resp #(.ADDR_W(10), .BASE(64'h8000_0000), .LATENCY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  exp_t   exp_q [3][$];
  int     n_pass  = 0;
  int     n_total = 0;
  longint cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (rst_n[g] && resp_valid[g] && resp_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp dut%0d: got rdata %h, required no response", g, resp_rdata[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("rdata dut%0d", g), resp_rdata[g], e.rdata);
          check($sformatf("err dut%0d", g), 64'(resp_err[g]), 64'(e.err));
        end
      end
    end
  end

  task automatic send(input int d, input logic we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] m, input logic [63:0] er, input logic ee);
    int k = 0;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_wmask[d] = m;
    @(negedge clk);
    while (!req_ready[d] && k < 100) begin @(negedge clk); k++; end
    if (!req_ready[d]) begin
      n_total++;
      $display("FAIL accept_timeout dut%0d: got req_ready 0, required 1", d);
    end
    exp_q[d].push_back('{rdata: er, err: ee});
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic lat_check(input int d, input int lat);
    int k = 0;
    do begin @(negedge clk); k++; end while (!resp_valid[d] && k < 100);
    check($sformatf("latency dut%0d", d), 64'(k), 64'(lat));
  endtask

  task automatic wait_ready(input int d);
    int k = 0;
    while (!req_ready[d] && k < 100) begin @(negedge clk); k++; end
    if (!req_ready[d]) begin
      n_total++;
      $display("FAIL ready_timeout dut%0d: got req_ready 0, required 1", d);
    end
  endtask

  task automatic txn(input int d, input vec_t v, input int lat);
    send(d, v.we, v.addr, v.wdata, v.wmask, v.rdata, v.err);
    lat_check(d, lat);
    wait_ready(d);
  endtask

  vec_t   vecs [16];
  longint acc  [4];

  initial begin
    vecs = '{
      '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0},
      '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0},
      '{1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b0},
      '{1'b0, 64'h8000_0017, 64'h0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0},
      '{1'b1, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 1'b0},
      '{1'b1, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0},
      '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1},
      '{1'b0, 64'h8000_2000, 64'h0, 8'h00, 64'h0, 1'b1},
      '{1'b1, 64'h7FFF_FFF8, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0, 1'b1},
      '{1'b1, 64'h8000_2000, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 1'b1},
      '{1'b1, 64'hFFFF_FFFF_8000_0000, 64'h7777_7777_7777_7777, 8'hFF, 64'h0, 1'b1},
      '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0},
      '{1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0},
      '{1'b1, 64'h8000_0000, 64'h0, 8'h81, 64'h0, 1'b0},
      '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h00AD_BEEF_CAFE_F000, 1'b0},
      '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0}
    };
    rst_n = '0; req_valid = '0; req_we = '0; resp_ready = '1;
    req_addr = '0; req_wdata = '0; req_wmask = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_err", 64'(resp_err), 64'd0);
    check("reset resp_rdata", resp_rdata[0], 64'd0);
    @(negedge clk);
    rst_n = '1;
    #1;
    check("req_ready before first edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("req_ready after first edge", 64'(req_ready), 64'h7);

    // LATENCY=2: data path, byte masks, range errors
    foreach (vecs[i]) txn(0, vecs[i], 2);

    // Backpressure on a load
    resp_ready[0] = 1'b0;
    send(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0);
    lat_check(0, 2);
    repeat (5) begin
      @(negedge clk);
      check("bp resp_valid", 64'(resp_valid[0]), 64'd1);
      check("bp resp_rdata", resp_rdata[0], 64'h1122_3344_FFFF_FFFF);
      check("bp req_ready", 64'(req_ready[0]), 64'd0);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp release resp_valid", 64'(resp_valid[0]), 64'd0);
    check("bp release req_ready", 64'(req_ready[0]), 64'd1);

    // LATENCY=4: reset in the middle of a store
    txn(1, '{1'b1, 64'h8000_0020, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 64'h0, 1'b0}, 4);
    txn(1, '{1'b0, 64'h8000_0020, 64'h0, 8'h00, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0}, 4);
    send(1, 1'b1, 64'h8000_0020, 64'hFFFF_0000_FFFF_0000, 8'hFF, 64'h0, 1'b0);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    check("midbusy rst req_ready", 64'(req_ready[1]), 64'd0);
    check("midbusy rst resp_valid", 64'(resp_valid[1]), 64'd0);
    check("midbusy rst resp_err", 64'(resp_err[1]), 64'd0);
    check("midbusy rst resp_rdata", resp_rdata[1], 64'd0);
    exp_q[1].delete();
    @(negedge clk);
    rst_n[1] = 1'b1;
    wait_ready(1);
    txn(1, '{1'b0, 64'h8000_0020, 64'h0, 8'h00, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0}, 4);

    // LATENCY=1: back-to-back loads with req_valid held high
    for (int i = 0; i < 4; i++)
      txn(2, '{1'b1, 64'h8000_0100 + 64'(8 * i), 64'h0101_0101_0101_0101 * 64'(i + 1),
               8'hFF, 64'h0, 1'b0}, 1);
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 64'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      @(negedge clk);
      while (!req_ready[2] && k < 20) begin @(negedge clk); k++; end
      acc[i] = cyc;
      exp_q[2].push_back('{rdata: 64'h0101_0101_0101_0101 * 64'(i + 1), err: 1'b0});
      @(posedge clk); #1;
      req_addr[2] = 64'h8000_0100 + 64'(8 * (i + 1));
    end
    req_valid[2] = 1'b0;
    for (int i = 1; i < 4; i++)
      check($sformatf("accept spacing %0d", i), 64'(acc[i] - acc[i-1]), 64'd2);
    wait_ready(2);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("scoreboard drained dut%0d", d), 64'(exp_q[d].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
